// File: rtl/construtor_caminho.sv
// -----------------------------------------------------------------------------
// construtor_caminho
//
// Path builder. On a rising edge of construir_in (while idle) it walks the
// predecessor memory backwards from destino_in until it reaches fonte_in,
// storing each visited node in an internal buffer (destination first). When
// the walk ends it pulses caminho_pronto_out for one cycle. It then exposes
// the path in source->destination order through a combinational read port.
//
// Ports:
//   clk, rst            clock / asynchronous active-high reset
//   construir_in        construct-path request (level, rising edge starts)
//   fonte_in            source node id, sampled on start
//   destino_in          destination node id, sampled on start
//   pred_rd_en_out      predecessor-memory read strobe
//   pred_addr_out       predecessor-memory address
//   pred_data_in        predecessor of addressed node (1 cycle after strobe)
//   pred_valido_in      addressed node was reached (same timing as data)
//   caminho_pronto_out  one-cycle pulse: walk finished (success or error)
//   erro_out            no path / overflow, held until next start
//   ocupado_out         high while the walk is in progress
//   comprimento_out     number of nodes in the path (0 on error)
//   rd_idx_in           path read index, 0 = source
//   rd_no_out           node at rd_idx_in (combinational)
// -----------------------------------------------------------------------------
module construtor_caminho #(
   parameter int NODE_WIDTH = 8,
   parameter int MAX_PATH   = 32,
   parameter int LEN_WIDTH  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  construir_in,
   input  logic [NODE_WIDTH-1:0] fonte_in,
   input  logic [NODE_WIDTH-1:0] destino_in,
   output logic                  pred_rd_en_out,
   output logic [NODE_WIDTH-1:0] pred_addr_out,
   input  logic [NODE_WIDTH-1:0] pred_data_in,
   input  logic                  pred_valido_in,
   output logic                  caminho_pronto_out,
   output logic                  erro_out,
   output logic                  ocupado_out,
   output logic [LEN_WIDTH-1:0]  comprimento_out,
   input  logic [LEN_WIDTH-1:0]  rd_idx_in,
   output logic [NODE_WIDTH-1:0] rd_no_out
);

   // Buffer address width (MAX_PATH is expected to be at least 2).
   localparam int AW = $clog2(MAX_PATH);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] GRAVAR = 3'd1;
   localparam logic [2:0] LER    = 3'd2;
   localparam logic [2:0] ESPERA = 3'd3;
   localparam logic [2:0] PRONTO = 3'd4;
   localparam logic [2:0] ERRO   = 3'd5;

   logic [2:0]            state_q, state_d;
   logic                  construir_prev_q;
   logic [NODE_WIDTH-1:0] fonte_q, fonte_d;
   logic [NODE_WIDTH-1:0] atual_q, atual_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  erro_q, erro_d;

   logic [NODE_WIDTH-1:0] buf_mem [0:MAX_PATH-1];
   logic                  buf_we;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  buf_cheio;
   logic                  inicio;

   assign inicio    = construir_in & ~construir_prev_q;
   assign buf_cheio = (len_q == LEN_WIDTH'(MAX_PATH));
   assign buf_we    = (state_q == GRAVAR) & ~buf_cheio;
   assign wr_ptr    = AW'(len_q);

   always_comb begin
      state_d = state_q;
      fonte_d = fonte_q;
      atual_d = atual_q;
      len_d   = len_q;
      erro_d  = erro_q;
      case (state_q)
         IDLE: begin
            if (inicio) begin
               fonte_d = fonte_in;
               atual_d = destino_in;
               len_d   = '0;
               erro_d  = 1'b0;
               state_d = GRAVAR;
            end
         end
         GRAVAR: begin
            // A predecessor cycle never reaches fonte; it ends here as overflow.
            if (buf_cheio) begin
               state_d = ERRO;
            end else begin
               len_d   = len_q + 1'b1;
               state_d = (atual_q == fonte_q) ? PRONTO : LER;
            end
         end
         LER: begin
            state_d = ESPERA;
         end
         ESPERA: begin
            if (!pred_valido_in) begin
               state_d = ERRO;
            end else begin
               atual_d = pred_data_in;
               state_d = GRAVAR;
            end
         end
         PRONTO: begin
            state_d = IDLE;
         end
         ERRO: begin
            erro_d  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= IDLE;
         construir_prev_q <= 1'b0;
         fonte_q          <= '0;
         atual_q          <= '0;
         len_q            <= '0;
         erro_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         construir_prev_q <= construir_in;
         fonte_q          <= fonte_d;
         atual_q          <= atual_d;
         len_q            <= len_d;
         erro_q           <= erro_d;
      end
   end

   // Buffer contents need no reset: they are only read below len_q.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_mem[wr_ptr] <= atual_q;
      end
   end

   // Moore outputs. erro_out is already high during the ERRO pulse cycle;
   // erro_q keeps it high afterwards until the next start.
   assign pred_rd_en_out     = (state_q == LER);
   assign pred_addr_out      = (state_q == LER) ? atual_q : '0;
   assign caminho_pronto_out = (state_q == PRONTO) | (state_q == ERRO);
   assign erro_out           = erro_q | (state_q == ERRO);
   assign ocupado_out        = (state_q == GRAVAR) | (state_q == LER) | (state_q == ESPERA);
   assign comprimento_out    = erro_out ? '0 : len_q;

   // Buffer is destination-first, so index 0 (source) is the last entry written.
   assign rd_ptr    = AW'(len_q - rd_idx_in - 1'b1);
   assign rd_no_out = ((rd_idx_in < len_q) && !erro_out) ? buf_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_construtor_caminho.sv
module tb_construtor_caminho;

   logic       clk = 1'b0;
   logic       rst;
   logic       construir_in;
   logic [7:0] fonte_in;
   logic [7:0] destino_in;
   logic       pred_rd_en_out;
   logic [7:0] pred_addr_out;
   logic [7:0] pred_data_in;
   logic       pred_valido_in;
   logic       caminho_pronto_out;
   logic       erro_out;
   logic       ocupado_out;
   logic [5:0] comprimento_out;
   logic [5:0] rd_idx_in;
   logic [7:0] rd_no_out;

   int checks = 0;
   int failures = 0;

   // Predecessor memory model (contents set by the stimulus block).
   logic [7:0] pred_mem [0:255];
   logic       pred_ok  [0:255];
   int         rd_total = 0;
   logic [7:0] rd_log [$];

   construtor_caminho dut (
      .clk                (clk),
      .rst                (rst),
      .construir_in       (construir_in),
      .fonte_in           (fonte_in),
      .destino_in         (destino_in),
      .pred_rd_en_out     (pred_rd_en_out),
      .pred_addr_out      (pred_addr_out),
      .pred_data_in       (pred_data_in),
      .pred_valido_in     (pred_valido_in),
      .caminho_pronto_out (caminho_pronto_out),
      .erro_out           (erro_out),
      .ocupado_out        (ocupado_out),
      .comprimento_out    (comprimento_out),
      .rd_idx_in          (rd_idx_in),
      .rd_no_out          (rd_no_out)
   );

   always #5 clk = ~clk;

   // One-cycle-latency memory response, plus a log of every read address.
   always @(posedge clk) begin
      if (pred_rd_en_out) begin
         pred_data_in   <= pred_mem[pred_addr_out];
         pred_valido_in <= pred_ok[pred_addr_out];
         rd_total       <= rd_total + 1;
         rd_log.push_back(pred_addr_out);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drops construir for one cycle, then raises it; returns just after edge k.
   task automatic start(input logic [7:0] f, input logic [7:0] d);
      construir_in = 1'b0;
      tick();
      fonte_in     = f;
      destino_in   = d;
      construir_in = 1'b1;
      tick();
   endtask

   // Offset (in cycles after the start edge k) at which the pulse is seen.
   task automatic wait_pulse(output int off, output logic err_at_pulse);
      off = 1;
      while (!caminho_pronto_out && off < 400) begin
         tick();
         off++;
      end
      err_at_pulse = erro_out;
      $display("transaction: fonte=%0d destino=%0d pulse_offset=%0d erro=%0b",
               fonte_in, destino_in, off, erro_out);
   endtask

   task automatic read_node(input logic [5:0] idx, input logic [7:0] exp, input string tag);
      rd_idx_in = idx;
      #1;
      chk(tag, {24'd0, rd_no_out}, {24'd0, exp});
   endtask

   initial begin
      int   off;
      int   base;
      logic ep;
      bit   seen;

      for (int i = 0; i < 256; i++) begin
         pred_mem[i] = 8'd0;
         pred_ok[i]  = 1'b0;
      end
      pred_data_in   = 8'd0;
      pred_valido_in = 1'b0;
      rst            = 1'b1;
      construir_in   = 1'b0;
      fonte_in       = 8'd0;
      destino_in     = 8'd0;
      rd_idx_in      = 6'd0;
      tick();
      tick();

      // Reset state
      chk("rst_pronto", {31'd0, caminho_pronto_out}, 32'd0);
      chk("rst_erro",   {31'd0, erro_out}, 32'd0);
      chk("rst_ocupado",{31'd0, ocupado_out}, 32'd0);
      chk("rst_rd_en",  {31'd0, pred_rd_en_out}, 32'd0);
      chk("rst_addr",   {24'd0, pred_addr_out}, 32'd0);
      chk("rst_len",    {26'd0, comprimento_out}, 32'd0);
      rst = 1'b0;
      tick();

      // Single-node path: fonte == destino
      base = rd_total;
      start(8'd5, 8'd5);
      wait_pulse(off, ep);
      chk("n1_offset", off, 2);
      chk("n1_erro_pulse", {31'd0, ep}, 32'd0);
      tick();
      chk("n1_reads", rd_total - base, 0);
      chk("n1_len", {26'd0, comprimento_out}, 32'd1);
      read_node(6'd0, 8'd5, "n1_rd0");

      // Four-node chain 9 -> 4 -> 2 -> 0
      pred_mem[9] = 8'd4; pred_ok[9] = 1'b1;
      pred_mem[4] = 8'd2; pred_ok[4] = 1'b1;
      pred_mem[2] = 8'd0; pred_ok[2] = 1'b1;
      base = rd_total;
      start(8'd0, 8'd9);
      wait_pulse(off, ep);
      chk("n4_offset", off, 11);
      chk("n4_erro_pulse", {31'd0, ep}, 32'd0);
      tick();
      chk("n4_reads", rd_total - base, 3);
      chk("n4_addr0", {24'd0, rd_log[base]},   32'd9);
      chk("n4_addr1", {24'd0, rd_log[base+1]}, 32'd4);
      chk("n4_addr2", {24'd0, rd_log[base+2]}, 32'd2);
      chk("n4_len", {26'd0, comprimento_out}, 32'd4);
      read_node(6'd0, 8'd0, "n4_rd0");
      read_node(6'd1, 8'd2, "n4_rd1");
      read_node(6'd2, 8'd4, "n4_rd2");
      read_node(6'd3, 8'd9, "n4_rd3");
      read_node(6'd4, 8'd0, "n4_rd4");

      // Unreached node 4 -> error after two writes
      pred_ok[4] = 1'b0;
      start(8'd0, 8'd9);
      wait_pulse(off, ep);
      chk("inv_offset", off, 7);
      chk("inv_erro_pulse", {31'd0, ep}, 32'd1);
      tick();
      chk("inv_erro", {31'd0, erro_out}, 32'd1);
      chk("inv_len", {26'd0, comprimento_out}, 32'd0);
      read_node(6'd0, 8'd0, "inv_rd0");
      pred_ok[4] = 1'b1;

      // Predecessor cycle 3 <-> 7: 32 writes, overflow on the 33rd attempt
      pred_mem[3] = 8'd7; pred_ok[3] = 1'b1;
      pred_mem[7] = 8'd3; pred_ok[7] = 1'b1;
      base = rd_total;
      start(8'd1, 8'd3);
      wait_pulse(off, ep);
      chk("cyc_offset", off, 98);
      chk("cyc_erro_pulse", {31'd0, ep}, 32'd1);
      tick();
      chk("cyc_reads", rd_total - base, 32);
      chk("cyc_len", {26'd0, comprimento_out}, 32'd0);

      // construir held high after the pulse: no restart
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (ocupado_out || caminho_pronto_out) seen = 1'b1;
         tick();
      end
      chk("hold_no_restart", {31'd0, seen}, 32'd0);
      chk("hold_erro_kept", {31'd0, erro_out}, 32'd1);

      // Re-raise with new destino: 4 -> 2 -> 0, erro cleared
      start(8'd0, 8'd4);
      chk("re_erro_clr", {31'd0, erro_out}, 32'd0);
      wait_pulse(off, ep);
      chk("re_offset", off, 8);
      tick();
      chk("re_len", {26'd0, comprimento_out}, 32'd3);
      read_node(6'd0, 8'd0, "re_rd0");
      read_node(6'd1, 8'd2, "re_rd1");
      read_node(6'd2, 8'd4, "re_rd2");

      // Reset during ESPERA of the 4-node walk
      start(8'd0, 8'd9);
      tick();
      tick();
      chk("mid_ocupado", {31'd0, ocupado_out}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_ocupado", {31'd0, ocupado_out}, 32'd0);
      chk("mid_rst_pronto",  {31'd0, caminho_pronto_out}, 32'd0);
      chk("mid_rst_len",     {26'd0, comprimento_out}, 32'd0);
      chk("mid_rst_rd_en",   {31'd0, pred_rd_en_out}, 32'd0);
      construir_in = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (caminho_pronto_out) seen = 1'b1;
      end
      rst = 1'b0;
      tick();
      if (caminho_pronto_out || ocupado_out) seen = 1'b1;
      chk("mid_no_pulse", {31'd0, seen}, 32'd0);
      start(8'd0, 8'd9);
      wait_pulse(off, ep);
      chk("post_offset", off, 11);
      tick();
      chk("post_len", {26'd0, comprimento_out}, 32'd4);
      read_node(6'd3, 8'd9, "post_rd3");
      read_node(6'd0, 8'd0, "post_rd0");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
